branch_history_table: RTL and testbench
=======================================

// Module: branch_history_table
// PURPOSE
//   Direct-mapped table of 2-bit saturating counters that produces the 2-bit prediction state for the
//   branch-prediction mux in IF. It indexes the table with the IF-stage PC and returns the state
//   combinationally in the same cycle. EX writes resolved branch outcomes back into the table.
//   The block also keeps saturating branch and mispredict event counters for performance monitoring.
// PARAMETERS
//   INDEX_BITS    6    log2 of entry count (64 entries); index = pc[INDEX_BITS+1:2]
//   CNT_WIDTH     32   width of the performance counters
//   RESET_STATE   2'b01  counter value loaded on reset/clear (weakly not-taken)
// PORTS
//   clk             in   1           rising-edge clock
//   rst_n           in   1           asynchronous active-low reset
//   if_pc           in   32          IF-stage PC to look up
//   prediction      out  2           counter state for if_pc; MSB=1 means predict taken
//   upd_valid       in   1           EX resolved a conditional branch this cycle
//   upd_pc          in   32          PC of the resolved branch
//   upd_taken       in   1           actual outcome: 1=taken
//   upd_mispredict  in   1           predicted direction differed from the outcome (qualified by upd_valid)
//   bht_clr         in   1           synchronous clear of every entry to RESET_STATE
//   branch_cnt      out  CNT_WIDTH   resolved branches since reset/clear
//   mispredict_cnt  out  CNT_WIDTH   mispredictions since reset/clear
// BEHAVIOUR
//   - Reset (rst_n=0, async): all 2^INDEX_BITS entries=RESET_STATE; branch_cnt=0; mispredict_cnt=0.
//     While in reset, prediction=RESET_STATE.
//   - Lookup is combinational, 0 cycles: prediction = table[if_pc[INDEX_BITS+1:2]]. pc[1:0] is ignored.
//   - Update is registered, 1 cycle: on a clk edge with upd_valid=1, entry u = upd_pc[INDEX_BITS+1:2]:
//       taken:     00->01->10->11->11 (saturates at 11)
//       not-taken: 11->10->01->00->00 (saturates at 00)
//   - Same-cycle bypass: if upd_valid=1 and both indices match, prediction shows the post-update value
//     computed this cycle, not the stored value.
//   - Aliasing: PCs that differ only above bit INDEX_BITS+1 share an entry; no tags are kept.
//   - bht_clr=1 at a clk edge: all entries=RESET_STATE and both counters=0. bht_clr overrides a
//     simultaneous update, so that update is dropped and not counted. While bht_clr=1,
//     prediction=RESET_STATE (bypass of the clear).
//   - Counters, on a clk edge with upd_valid=1 and bht_clr=0:
//       branch_cnt increments by 1;
//       mispredict_cnt increments by 1 when upd_mispredict=1.
//     Both saturate at all-ones and do not wrap. upd_mispredict is ignored when upd_valid=0.
//   - Reset asserted mid-operation forces every state to the reset values immediately.
//     The first update after rst_n deasserts takes effect at the next clk edge.
//   - No X propagation: an X on if_pc must not corrupt stored state; only upd_* and bht_clr write state.
// TESTING
//   1. Reset, then sweep if_pc 0x0..0xFC step 4 -> prediction=2'b01 for every entry; both counters=0.
//   2. upd_pc=0x40 taken x3 -> prediction at if_pc=0x40 goes 10, 11, 11; branch_cnt=3.
//      Then not-taken x4 -> 10, 01, 00, 00.
//   3. Aliasing (INDEX_BITS=6): one taken update at upd_pc=0x100 -> if_pc=0x000 reads 2'b10;
//      if_pc=0x004 still reads 2'b01.
//   4. Bypass: if_pc=upd_pc=0x80, entry=01, upd_valid=1, upd_taken=1 -> prediction=2'b10 in the
//      same cycle; stored value=10 after the edge.
//   5. bht_clr and upd_valid(mispredict=1) in the same cycle, after 5 updates -> all entries=01;
//      branch_cnt=0; mispredict_cnt=0; the update is not applied.
//   6. CNT_WIDTH=4: 20 mispredicting updates -> branch_cnt=mispredict_cnt=4'hF (saturated).
//      Then assert rst_n=0 between edges -> counters=0 and entries=01 without waiting for a clk edge.

Source files
------------

// File: rtl/branch_history_table.sv
// -----------------------------------------------------------------------------
// branch_history_table
//
// Direct-mapped table of 2-bit saturating branch counters. The IF stage looks
// up a prediction combinationally. The EX stage writes resolved outcomes back
// one clock later. Saturating event counters track resolved branches and
// mispredictions for performance monitoring.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   if_pc           IF-stage PC to look up; index = if_pc[INDEX_BITS+1:2]
//   prediction      counter state for if_pc; MSB=1 means predict taken
//   upd_valid       EX resolved a conditional branch this cycle
//   upd_pc          PC of the resolved branch
//   upd_taken       actual outcome, 1 = taken
//   upd_mispredict  resolved direction differed from the prediction
//   bht_clr         synchronous clear of all entries and counters
//   branch_cnt      resolved branches since reset/clear (saturating)
//   mispredict_cnt  mispredictions since reset/clear (saturating)
// -----------------------------------------------------------------------------
module branch_history_table #(
   parameter int         INDEX_BITS  = 6,
   parameter int         CNT_WIDTH   = 32,
   parameter logic [1:0] RESET_STATE = 2'b01
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          if_pc,
   output logic [1:0]           prediction,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic                 upd_taken,
   input  logic                 upd_mispredict,
   input  logic                 bht_clr,
   output logic [CNT_WIDTH-1:0] branch_cnt,
   output logic [CNT_WIDTH-1:0] mispredict_cnt
);

   localparam int                   ENTRIES = 1 << INDEX_BITS;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            bht_q [ENTRIES];
   logic [INDEX_BITS-1:0] rd_idx;
   logic [INDEX_BITS-1:0] wr_idx;
   logic [1:0]            upd_state;

   // Only the index bits of either PC are meaningful; the rest is dropped.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0],
                             upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

   // Two-bit saturating counter step toward the resolved direction.
   function automatic logic [1:0] counter_step(input logic [1:0] state,
                                               input logic       taken);
      logic [1:0] nxt;
      nxt = state;
      if (taken) begin
         if (state != 2'b11) nxt = state + 2'b01;
      end else begin
         if (state != 2'b00) nxt = state - 2'b01;
      end
      return nxt;
   endfunction

   // Event counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic                 en);
      logic [CNT_WIDTH-1:0] nxt;
      nxt = cnt;
      if (en && (cnt != {CNT_WIDTH{1'b1}})) nxt = cnt + CNT_ONE;
      return nxt;
   endfunction

   assign rd_idx    = if_pc[INDEX_BITS+1:2];
   assign wr_idx    = upd_pc[INDEX_BITS+1:2];
   assign upd_state = counter_step(bht_q[wr_idx], upd_taken);

   // Lookup: a pending clear or a same-index update is forwarded so IF sees
   // the value the table will hold after this edge.
   always_comb begin
      prediction = bht_q[rd_idx];
      if (!rst_n || bht_clr) begin
         prediction = RESET_STATE;
      end else if (upd_valid && (rd_idx == wr_idx)) begin
         prediction = upd_state;
      end
   end

   // Table storage: clear has priority over a simultaneous update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) bht_q[i] <= RESET_STATE;
      end else if (bht_clr) begin
         for (int i = 0; i < ENTRIES; i++) bht_q[i] <= RESET_STATE;
      end else if (upd_valid) begin
         bht_q[wr_idx] <= upd_state;
      end
   end

   // Performance counters; an update dropped by a clear is not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else if (bht_clr) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else begin
         branch_cnt     <= sat_inc(branch_cnt, upd_valid);
         mispredict_cnt <= sat_inc(mispredict_cnt, upd_valid && upd_mispredict);
      end
   end

endmodule

// File: tb/tb_branch_history_table.sv
// -----------------------------------------------------------------------------
// tb_branch_history_table
//
// Directed bench for branch_history_table (INDEX_BITS=6, CNT_WIDTH=4).
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_branch_history_table;

   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic [31:0]   if_pc;
   logic [1:0]    prediction;
   logic          upd_valid;
   logic [31:0]   upd_pc;
   logic          upd_taken;
   logic          upd_mispredict;
   logic          bht_clr;
   logic [CW-1:0] branch_cnt;
   logic [CW-1:0] mispredict_cnt;

   int n_vec = 0;
   int n_bad = 0;

   branch_history_table #(
      .INDEX_BITS (6),
      .CNT_WIDTH  (CW),
      .RESET_STATE(2'b01)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_pc         (if_pc),
      .prediction    (prediction),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_taken     (upd_taken),
      .upd_mispredict(upd_mispredict),
      .bht_clr       (bht_clr),
      .branch_cnt    (branch_cnt),
      .mispredict_cnt(mispredict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One registered update, then drop upd_valid so reads see stored state.
   task automatic do_upd(input logic [31:0] pc, input logic taken, input logic misp);
      upd_pc         = pc;
      upd_taken      = taken;
      upd_mispredict = misp;
      upd_valid      = 1'b1;
      tick();
      upd_valid      = 1'b0;
      upd_mispredict = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [31:0] pc, input logic [1:0] exp);
      if_pc = pc;
      #1;
      chk(tag, {30'd0, prediction}, {30'd0, exp});
   endtask

   logic [1:0] exp_t [3];
   logic [1:0] exp_n [4];

   initial begin
      rst_n          = 1'b1;
      if_pc          = 32'h0;
      upd_valid      = 1'b0;
      upd_pc         = 32'h0;
      upd_taken      = 1'b0;
      upd_mispredict = 1'b0;
      bht_clr        = 1'b0;
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk("rst_pred", {30'd0, prediction}, 32'h1);
      chk("rst_bcnt", {28'd0, branch_cnt}, 32'h0);
      chk("rst_mcnt", {28'd0, mispredict_cnt}, 32'h0);
      rst_n = 1'b1;
      tick();

      // 1: every entry at reset state
      for (int pc = 0; pc <= 32'hFC; pc += 4) read_chk("sweep", pc, 2'b01);
      chk("sweep_bcnt", {28'd0, branch_cnt}, 32'h0);
      chk("sweep_mcnt", {28'd0, mispredict_cnt}, 32'h0);

      // 2: saturate up, then down
      exp_t = '{2'b10, 2'b11, 2'b11};
      for (int k = 0; k < 3; k++) begin
         do_upd(32'h40, 1'b1, 1'b0);
         read_chk("taken_step", 32'h40, exp_t[k]);
      end
      chk("taken_bcnt", {28'd0, branch_cnt}, 32'd3);
      exp_n = '{2'b10, 2'b01, 2'b00, 2'b00};
      for (int k = 0; k < 4; k++) begin
         do_upd(32'h40, 1'b0, (k < 2) ? 1'b1 : 1'b0);
         read_chk("ntaken_step", 32'h40, exp_n[k]);
      end
      chk("ntaken_bcnt", {28'd0, branch_cnt}, 32'd7);
      chk("ntaken_mcnt", {28'd0, mispredict_cnt}, 32'd2);
      // mispredict without valid is ignored
      upd_mispredict = 1'b1;
      tick();
      upd_mispredict = 1'b0;
      chk("novalid_bcnt", {28'd0, branch_cnt}, 32'd7);
      chk("novalid_mcnt", {28'd0, mispredict_cnt}, 32'd2);

      // 3: aliasing and ignored low PC bits
      do_upd(32'h100, 1'b1, 1'b0);
      read_chk("alias_0", 32'h000, 2'b10);
      read_chk("alias_4", 32'h004, 2'b01);
      read_chk("alias_lowbits", 32'h003, 2'b10);
      chk("alias_bcnt", {28'd0, branch_cnt}, 32'd8);

      // 4: same-cycle bypass, and no bypass on a different index
      if_pc     = 32'h84;
      upd_pc    = 32'h80;
      upd_taken = 1'b1;
      upd_valid = 1'b1;
      #1;
      chk("bypass_other", {30'd0, prediction}, 32'h1);
      if_pc = 32'h80;
      #1;
      chk("bypass_same", {30'd0, prediction}, 32'h2);
      tick();
      upd_valid = 1'b0;
      read_chk("bypass_stored", 32'h80, 2'b10);
      chk("bypass_bcnt", {28'd0, branch_cnt}, 32'd9);

      // 5: clear beats a simultaneous update
      for (int k = 0; k < 5; k++) do_upd(32'h40, 1'b1, 1'b1);
      read_chk("preclr_pred", 32'h40, 2'b11);
      chk("preclr_bcnt", {28'd0, branch_cnt}, 32'd14);
      chk("preclr_mcnt", {28'd0, mispredict_cnt}, 32'd7);
      upd_pc         = 32'h40;
      upd_taken      = 1'b1;
      upd_mispredict = 1'b1;
      upd_valid      = 1'b1;
      bht_clr        = 1'b1;
      #1;
      chk("clr_bypass", {30'd0, prediction}, 32'h1);
      tick();
      bht_clr        = 1'b0;
      upd_valid      = 1'b0;
      upd_mispredict = 1'b0;
      chk("clr_bcnt", {28'd0, branch_cnt}, 32'h0);
      chk("clr_mcnt", {28'd0, mispredict_cnt}, 32'h0);
      read_chk("clr_40", 32'h40, 2'b01);
      read_chk("clr_00", 32'h00, 2'b01);
      read_chk("clr_80", 32'h80, 2'b01);

      // 6: counter saturation, then async reset between edges
      for (int k = 0; k < 20; k++) do_upd(32'hC0, 1'b1, 1'b1);
      chk("sat_bcnt", {28'd0, branch_cnt}, 32'hF);
      chk("sat_mcnt", {28'd0, mispredict_cnt}, 32'hF);
      read_chk("sat_pred", 32'hC0, 2'b11);
      rst_n = 1'b0;
      #1;
      chk("arst_bcnt", {28'd0, branch_cnt}, 32'h0);
      chk("arst_mcnt", {28'd0, mispredict_cnt}, 32'h0);
      chk("arst_pred", {30'd0, prediction}, 32'h1);
      #1 rst_n = 1'b1;
      #1;
      read_chk("arst_stored", 32'hC0, 2'b01);
      do_upd(32'hC0, 1'b1, 1'b1);
      read_chk("post_rst_pred", 32'hC0, 2'b10);
      chk("post_rst_bcnt", {28'd0, branch_cnt}, 32'd1);
      chk("post_rst_mcnt", {28'd0, mispredict_cnt}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
